// File: rtl/eeprom_pkg.sv
// Shared encodings for the EEPROM array controller: command codes, FSM states
// and the default erased-byte value.
package eeprom_pkg;

   localparam int unsigned CMD_W   = 2;
   localparam int unsigned STATE_W = 3;

   localparam logic [CMD_W-1:0] CMD_READ  = 2'b00;
   localparam logic [CMD_W-1:0] CMD_ERASE = 2'b01;
   localparam logic [CMD_W-1:0] CMD_WRITE = 2'b10;
   localparam logic [CMD_W-1:0] CMD_RSVD  = 2'b11;

   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_READ   = 3'd1;
   localparam logic [STATE_W-1:0] ST_ERASE  = 3'd2;
   localparam logic [STATE_W-1:0] ST_GAP_E  = 3'd3;
   localparam logic [STATE_W-1:0] ST_PROG   = 3'd4;
   localparam logic [STATE_W-1:0] ST_GAP_P  = 3'd5;
   localparam logic [STATE_W-1:0] ST_VERIFY = 3'd6;
   localparam logic [STATE_W-1:0] ST_RESP   = 3'd7;

   localparam logic [7:0] ERASED_VAL_DEF = 8'hFF;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/eeprom_ctrl.sv
// EEPROM array initiator: sequences READ, ERASE and WRITE (erase/program/verify)
// with programmed strobe hold times and returns one response per command.
module eeprom_ctrl
   import eeprom_pkg::*;
#(
   parameter int unsigned        ADDR_W     = 4,
   parameter int unsigned        DATA_W     = 8,
   parameter int unsigned        ERASE_CYC  = 4,
   parameter int unsigned        PROG_CYC   = 4,
   parameter int unsigned        RD_CYC     = 1,
   parameter logic [DATA_W-1:0]  ERASED_VAL = DATA_W'(ERASED_VAL_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CMD_W-1:0]  req_cmd,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_erase,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_MAX = max3(ERASE_CYC, PROG_CYC, RD_CYC);
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   logic [STATE_W-1:0] state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CMD_W-1:0]   cmd_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rsp_data_nxt;
   logic               rsp_err_nxt;
   logic               accept_c;
   logic [DATA_W-1:0]  verify_exp_c;

   assign accept_c     = (state == ST_IDLE) && req_valid && req_ready;
   assign verify_exp_c = (cmd_q == CMD_WRITE) ? wdata_q : ERASED_VAL;

   // State, counter, captured request and all outputs (outputs follow the next state)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cmd_q     <= CMD_READ;
         wdata_q   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_erase <= 1'b0;
         mem_wdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_ready <= (state_nxt == ST_IDLE);
         busy      <= (state_nxt != ST_IDLE);
         rsp_valid <= (state_nxt == ST_RESP);
         mem_erase <= (state_nxt == ST_ERASE);
         mem_we    <= (state_nxt == ST_PROG);
         mem_wdata <= (state_nxt == ST_PROG) ? wdata_q : '0;
         rsp_data  <= rsp_data_nxt;
         rsp_err   <= rsp_err_nxt;
         if (accept_c) begin
            cmd_q    <= req_cmd;
            wdata_q  <= req_wdata;
            mem_addr <= req_addr;
         end
      end
   end

   // Next state; the counter is loaded on state entry and the state advances at zero
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
      rsp_data_nxt = rsp_data;
      rsp_err_nxt  = rsp_err;
      unique case (state)
         ST_IDLE: begin
            if (accept_c) begin
               unique case (req_cmd)
                  CMD_READ: begin
                     state_nxt = ST_READ;
                     cnt_nxt   = CNT_W'(RD_CYC - 1);
                  end
                  CMD_ERASE, CMD_WRITE: begin
                     state_nxt = ST_ERASE;
                     cnt_nxt   = CNT_W'(ERASE_CYC - 1);
                  end
                  default: begin
                     state_nxt    = ST_RESP;
                     rsp_data_nxt = '0;
                     rsp_err_nxt  = 1'b1;
                  end
               endcase
            end
         end
         ST_READ: begin
            if (cnt == '0) begin
               state_nxt    = ST_RESP;
               rsp_data_nxt = mem_rdata;
               rsp_err_nxt  = 1'b0;
            end
         end
         ST_ERASE: begin
            if (cnt == '0) state_nxt = ST_GAP_E;
         end
         ST_GAP_E: begin
            if (cmd_q == CMD_WRITE) begin
               state_nxt = ST_PROG;
               cnt_nxt   = CNT_W'(PROG_CYC - 1);
            end else begin
               state_nxt = ST_VERIFY;
               cnt_nxt   = CNT_W'(RD_CYC - 1);
            end
         end
         ST_PROG: begin
            if (cnt == '0) state_nxt = ST_GAP_P;
         end
         ST_GAP_P: begin
            state_nxt = ST_VERIFY;
            cnt_nxt   = CNT_W'(RD_CYC - 1);
         end
         ST_VERIFY: begin
            if (cnt == '0) begin
               state_nxt    = ST_RESP;
               rsp_data_nxt = mem_rdata;
               rsp_err_nxt  = (mem_rdata != verify_exp_c);
            end
         end
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Bench for eeprom_ctrl: array model beside the controller, directed scenarios
// then random commands checked against a byte-array reference.
module tb_eeprom_ctrl;
   import eeprom_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_cmd;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       busy;
   logic [3:0] mem_addr;
   logic       mem_we;
   logic       mem_erase;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   logic       arr_load;
   logic       fault_en;
   logic [7:0] arr     [16];
   logic [7:0] ref_mem [16];

   int checks = 0;
   int errors = 0;

   eeprom_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_erase(mem_erase),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      return (i == 5) ? 8'h3C : 8'(i * 17 + 3);
   endfunction

   // Array macro model; the fault switch makes programming at address 8 ineffective
   always @(posedge clk) begin
      if (arr_load) begin
         for (int i = 0; i < 16; i++) arr[i] <= init_val(i);
      end else if (mem_erase) begin
         arr[mem_addr] <= 8'hFF;
      end else if (mem_we && !(fault_en && mem_addr == 4'd8)) begin
         arr[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = arr[mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command, watch the array port until the response, compare to the reference
   task automatic run_cmd(input logic [1:0] c, input logic [3:0] a, input logic [7:0] d,
                          input bit hold, output int waits);
      logic [7:0] exp_d;
      logic       exp_e;
      int         exp_lat, exp_er, exp_we;
      int         lat, n_er, n_we, first_we, last_er;
      bit         both, addr_ok, wd_ok, busy_ok;
      logic [7:0] got_d;
      logic       got_e;
      lat = 0; n_er = 0; n_we = 0; first_we = -1; last_er = -1;
      both = 0; addr_ok = 1; wd_ok = 1; busy_ok = 1;
      got_d = 'x; got_e = 'x;
      exp_er = 0; exp_we = 0;
      case (c)
         CMD_READ: begin
            exp_d = ref_mem[a]; exp_e = 1'b0; exp_lat = 2;
         end
         CMD_ERASE: begin
            ref_mem[a] = 8'hFF;
            exp_d = 8'hFF; exp_e = 1'b0; exp_lat = 4 + 1 + 2; exp_er = 4;
         end
         CMD_WRITE: begin
            exp_er = 4; exp_we = 4; exp_lat = 4 + 4 + 1 + 3;
            if (fault_en && a == 4'd8) begin
               ref_mem[a] = 8'hFF; exp_d = 8'hFF; exp_e = 1'b1;
            end else begin
               ref_mem[a] = d; exp_d = d; exp_e = 1'b0;
            end
         end
         default: begin
            exp_d = 8'h00; exp_e = 1'b1; exp_lat = 1;
         end
      endcase

      req_cmd = c; req_addr = a; req_wdata = d; req_valid = 1'b1;
      waits = 0;
      while (!req_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      check("accept", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (mem_erase) begin n_er++; last_er = k; end
         if (mem_we) begin
            n_we++;
            if (first_we < 0) first_we = k;
            if (mem_wdata !== d) wd_ok = 0;
         end
         if (mem_erase && mem_we) both = 1;
         if (mem_addr !== a) addr_ok = 0;
         if (req_ready !== 1'b0 || busy !== 1'b1) busy_ok = 0;
         if (rsp_valid) begin
            lat = k; got_d = rsp_data; got_e = rsp_err;
            break;
         end
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("rsp_data", 32'(got_d), 32'(exp_d));
      check("rsp_err", 32'(got_e), 32'(exp_e));
      check("erase_cycles", 32'(n_er), 32'(exp_er));
      check("prog_cycles", 32'(n_we), 32'(exp_we));
      check("strobe_overlap", 32'(both), 32'd0);
      check("addr_stable", 32'(addr_ok), 32'd1);
      check("busy_no_ready", 32'(busy_ok), 32'd1);
      if (c == CMD_WRITE) begin
         check("prog_gap", 32'(first_we - last_er), 32'd2);
         check("prog_wdata", 32'(wd_ok), 32'd1);
      end
      @(negedge clk);
      check("rsp_pulse", 32'(rsp_valid), 32'd0);
      check("rsp_hold", 32'({rsp_data, rsp_err}), 32'({exp_d, exp_e}));
      check("idle_ready", 32'({busy, req_ready}), 32'b01);
   endtask

   initial begin
      int w;
      int cnt;
      rst_n = 1'b0; arr_load = 1'b1; fault_en = 1'b0;
      req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

      // Reset values
      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({req_ready, rsp_valid, rsp_data, rsp_err, busy, mem_addr, mem_we,
                 mem_erase, mem_wdata}), 32'd0);
      rst_n = 1'b1; arr_load = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'({req_ready, busy}), 32'b10);

      // Directed commands
      run_cmd(CMD_READ,  4'd5,  8'h00, 1'b0, w);
      run_cmd(CMD_WRITE, 4'd2,  8'hAA, 1'b0, w);
      run_cmd(CMD_READ,  4'd2,  8'h00, 1'b0, w);
      run_cmd(CMD_ERASE, 4'd15, 8'h00, 1'b0, w);
      run_cmd(CMD_READ,  4'd15, 8'h00, 1'b0, w);
      run_cmd(CMD_READ,  4'd0,  8'h00, 1'b0, w);
      fault_en = 1'b1;
      run_cmd(CMD_WRITE, 4'd8,  8'hCC, 1'b0, w);
      fault_en = 1'b0;
      run_cmd(CMD_RSVD,  4'd4,  8'h55, 1'b0, w);

      // Request held through a WRITE: next acceptance in the first IDLE cycle
      run_cmd(CMD_WRITE, 4'd6, 8'h5A, 1'b1, w);
      run_cmd(CMD_WRITE, 4'd6, 8'h5A, 1'b0, w);
      check("held_req_wait", 32'(w), 32'd0);

      // Reset in the middle of a program pulse
      req_cmd = CMD_WRITE; req_addr = 4'd3; req_wdata = 8'h77; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin @(negedge clk); w++; end
      @(posedge clk);
      #1 req_valid = 1'b0;
      w = 0;
      while (!mem_we && w < 30) begin @(negedge clk); w++; end
      check("reach_prog", 32'(mem_we), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("reset_mid_prog", 32'({mem_we, mem_erase, rsp_valid, busy, req_ready}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      check("no_rsp_after_reset", 32'(cnt), 32'd0);
      run_cmd(CMD_READ,  4'd0, 8'h00, 1'b0, w);
      run_cmd(CMD_WRITE, 4'd3, 8'h81, 1'b0, w);
      run_cmd(CMD_READ,  4'd3, 8'h00, 1'b0, w);

      // Random commands against the reference array
      for (int n = 0; n < 24; n++) begin
         run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 1'b0, w);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
